psx_controller_emu: RTL and testbench
=====================================

Name: psx_controller_emu

Overview:
- Synchronous, oversampling PlayStation controller emulator: one system clock, no logic clocked by psx_clk or att.
- Parametrised successor of the fixed-data fake controller:
  - live button/stick inputs replace the hard-wired data parameters;
  - decodes host commands 0x01/0x42 and aborts on mismatch;
  - selectable digital (ID 0x41, 5 bytes) or analog (ID 0x73, 9 bytes) reply;
  - parametrised ACK delay and width.
- Sits between the FPGA pin synchronizers and the button source; drives the data and ack lines toward the console.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the psx_clk/att/cmd synchronizers (min 2).
- ACK_DELAY, 8, clk cycles from the last rising psx_clk edge of a byte to ack falling.
- ACK_WIDTH, 4, clk cycles ack is held low (min 1).
- DIGITAL_ID, 8'h41, byte1 reply in digital mode.
- ANALOG_ID, 8'h73, byte1 reply in analog mode.

Ports:
- clk  in  1  system clock; must be at least 8x psx_clk frequency.
- rst  in  1  synchronous, active-high reset.
- psx_clk  in  1  console serial clock, asynchronous, idle high.
- att  in  1  console attention, active low, asynchronous.
- cmd  in  1  console command bit, LSB first.
- buttons  in  16  active-low buttons; [7:0]=DATA1 (SLCT..LEFT), [15:8]=DATA2 (L2..SQUARE).
- sticks  in  32  {LY,LX,RY,RX}, RX in [7:0].
- analog_mode  in  1  sampled at att falling; 1 selects 9-byte analog reply.
- data  out  1  controller data bit, idle 1.
- ack  out  1  active-low acknowledge, idle 1.
- busy  out  1  high while selected and not in DONE.

Behaviour:
- Reset: data=1, ack=1, busy=0, state=IDLE, all counters 0. Reset is synchronous and overrides every other event, including mid-byte.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the last two stages. Pin-to-edge latency is SYNC_STAGES+1 clk.
- Reply buffer, loaded at att fall: {sticks, buttons, 8'h5A, ID}. ID and byte count (5 or 9) are latched from analog_mode at that instant.
- States:
  - IDLE: on synced att falling -> SHIFT. Load buffer, byte_idx=0, bit_idx=0, busy=1.
  - SHIFT:
    - psx_clk falling -> data = reply bit (byte_idx, bit_idx). Byte 0 drives 1 for all bits.
    - psx_clk rising -> shift cmd into rx[7:0] (LSB first), bit_idx+1.
    - After the 8th rising edge, check the byte:
      - byte0 != 8'h01 -> DONE;
      - byte1 != 8'h42 -> DONE;
      - byte_idx == last -> DONE;
      - otherwise -> ACK_WAIT with delay counter 0.
  - ACK_WAIT: count ACK_DELAY cycles -> ACK_LOW, ack=0. A psx_clk falling edge in this state still advances the data bit (host ignored ACK); go to SHIFT and skip the ack.
  - ACK_LOW: hold ack=0 for ACK_WIDTH cycles, then ack=1, byte_idx+1, bit_idx=0 -> SHIFT.
  - DONE: data=1, ack=1, busy=0; ignore psx_clk until att rises.
- From any non-IDLE state, synced att rising -> IDLE in the same cycle: data=1, ack=1, busy=0. A partially driven ack is cut short.
- Simultaneous att rise and psx_clk edge in one cycle: att wins.
- No ACK after the final byte.
- buttons/sticks changes during a transfer do not affect it (snapshot).
- byte_idx is 4 bits and saturates at the last byte; it never wraps.

Decomposition:
- Package psx_pkg holds:
  - command constants CMD_START=8'h01, CMD_POLL=8'h42, READY=8'h5A;
  - the state enum;
  - byte-count constants DIG_BYTES=5, ANA_BYTES=9.
- Sub-module psx_sync_edge: a SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated three times (psx_clk, att, cmd; edge outputs unused for cmd).

Test Plan:
- Digital poll: analog_mode=0, buttons=16'hFDFE, host sends 01 42 00 00 00 -> data bytes FF 41 5A FE FD. Four ack pulses, each ACK_WIDTH=4 clk low, beginning ACK_DELAY=8 clk after byte end. No ack after byte 4.
- Analog poll: analog_mode=1, sticks=32'h80807F10 -> replies FF 73 5A, buttons, 10 7F 80 80. Eight acks; busy falls after byte 8.
- Wrong address: host byte0=8'h81 -> no ack, data stays 1 until att rises. The next att cycle with 01 42 replies normally.
- att deasserted mid byte 3 (after 4 bits) -> within SYNC_STAGES+1 clk: data=1, ack=1, busy=0, state IDLE.
- Reset asserted while ack=0 in ACK_LOW -> next clk: ack=1, data=1, busy=0; a fresh poll afterwards returns the correct bytes.
- Buttons change from FFFF to FFFE during byte 2 -> reply still carries FF FF (snapshot at att fall).

Source files
------------

// File: rtl/psx_pkg.sv
// rtl/psx_pkg.sv - shared constants, state encoding and reply helpers for the PSX controller emulator
package psx_pkg;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] READY     = 8'h5A;

  localparam logic [3:0] DIG_BYTES = 4'd5;
  localparam logic [3:0] ANA_BYTES = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACK_WAIT,
    ST_ACK_LOW,
    ST_DONE
  } psx_state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] last);
    return (v < last) ? v + 4'd1 : last;
  endfunction

  // Byte 0 is the idle/address slot; bytes 1.. come from the snapshot buffer.
  function automatic logic reply_bit(input logic [63:0] rbuf, input logic [3:0] bidx,
                                     input logic [2:0] bit_i);
    logic [2:0] slot;
    slot = 3'(bidx - 4'd1);
    return (bidx == 4'd0) ? 1'b1 : rbuf[{slot, bit_i}];
  endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// rtl/psx_sync_edge.sv - multi-flop pin synchronizer with rise/fall pulses on the settled level
module psx_sync_edge
  import psx_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{INIT}};
      last_q <= INIT;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~last_q;
  assign fall  = ~level & last_q;

endmodule

// File: rtl/psx_controller_emu.sv
// rtl/psx_controller_emu.sv - oversampling PlayStation controller emulator (digital/analog poll reply)
module psx_controller_emu
  import psx_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         ACK_DELAY   = 8,
  parameter int         ACK_WIDTH   = 4,
  parameter logic [7:0] DIGITAL_ID  = 8'h41,
  parameter logic [7:0] ANALOG_ID   = 8'h73
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psx_clk,
  input  logic        att,
  input  logic        cmd,
  input  logic [15:0] buttons,
  input  logic [31:0] sticks,
  input  logic        analog_mode,
  output logic        data,
  output logic        ack,
  output logic        busy
);

  localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic clk_rise, clk_fall, att_rise, att_fall, cmd_s;
  logic psx_clk_level_unused, att_level_unused, cmd_rise_unused, cmd_fall_unused;

  psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .din(psx_clk),
    .level(psx_clk_level_unused), .rise(clk_rise), .fall(clk_fall)
  );

  psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_att (
    .clk(clk), .rst(rst), .din(att),
    .level(att_level_unused), .rise(att_rise), .fall(att_fall)
  );

  psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cmd (
    .clk(clk), .rst(rst), .din(cmd),
    .level(cmd_s), .rise(cmd_rise_unused), .fall(cmd_fall_unused)
  );

  psx_state_t    state_q, state_n;
  logic          data_q, data_n, ack_q, ack_n;
  logic [3:0]    byte_idx, byte_n, last_idx, last_n, next_byte;
  logic [2:0]    bit_idx, bit_n;
  logic [6:0]    rx_q, rx_n;   // eighth bit is taken straight from cmd_s when the byte closes
  logic [7:0]    rx_byte;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [63:0]   reply_buf, buf_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= 1'b1;
      ack_q     <= 1'b1;
      byte_idx  <= '0;
      bit_idx   <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      reply_buf <= '0;
      last_idx  <= '0;
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      ack_q     <= ack_n;
      byte_idx  <= byte_n;
      bit_idx   <= bit_n;
      rx_q      <= rx_n;
      cnt_q     <= cnt_n;
      reply_buf <= buf_n;
      last_idx  <= last_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    data_n    = data_q;
    ack_n     = ack_q;
    byte_n    = byte_idx;
    bit_n     = bit_idx;
    rx_n      = rx_q;
    cnt_n     = cnt_q;
    buf_n     = reply_buf;
    last_n    = last_idx;
    rx_byte   = {cmd_s, rx_q};
    next_byte = sat_inc(byte_idx, last_idx);

    if (state_q != ST_IDLE && att_rise) begin
      state_n = ST_IDLE;
      data_n  = 1'b1;
      ack_n   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (att_fall) begin
            state_n  = ST_SHIFT;
            buf_n    = {sticks, buttons, READY, analog_mode ? ANALOG_ID : DIGITAL_ID};
            last_n   = analog_mode ? (ANA_BYTES - 4'd1) : (DIG_BYTES - 4'd1);
            byte_n   = '0;
            bit_n    = '0;
            rx_n     = '0;
            cnt_n    = '0;
          end
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            data_n = reply_bit(reply_buf, byte_idx, bit_idx);
          end else if (clk_rise) begin
            rx_n  = rx_byte[7:1];
            bit_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if ((byte_idx == 4'd0 && rx_byte != CMD_START) ||
                  (byte_idx == 4'd1 && rx_byte != CMD_POLL) ||
                  (byte_idx == last_idx)) begin
                state_n = ST_DONE;
                data_n  = 1'b1;
              end else begin
                state_n = ST_ACK_WAIT;
                cnt_n   = '0;
              end
            end
          end
        end
        ST_ACK_WAIT, ST_ACK_LOW: begin
          // A host that clocks on without waiting for ack moves straight to the next byte.
          if (clk_fall) begin
            state_n = ST_SHIFT;
            ack_n   = 1'b1;
            byte_n  = next_byte;
            bit_n   = '0;
            data_n  = reply_bit(reply_buf, next_byte, 3'd0);
          end else if (state_q == ST_ACK_WAIT) begin
            if (cnt_q >= CW'(ACK_DELAY - 1)) begin
              state_n = ST_ACK_LOW;
              ack_n   = 1'b0;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end else if (cnt_q >= CW'(ACK_WIDTH - 1)) begin
            state_n = ST_SHIFT;
            ack_n   = 1'b1;
            byte_n  = next_byte;
            bit_n   = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          data_n = 1'b1;
          ack_n  = 1'b1;
        end
        default: begin
          state_n = ST_IDLE;
          data_n  = 1'b1;
          ack_n   = 1'b1;
        end
      endcase
    end
  end

  assign data = data_q;
  assign ack  = ack_q;
  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_psx_controller_emu.sv
// tb/tb_psx_controller_emu.sv - scoreboard bench: host polls, reply-byte and ack checks
module tb_psx_controller_emu;
  import psx_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int ACK_DELAY   = 8;
  localparam int ACK_WIDTH   = 4;
  localparam int HALF        = 8;
  localparam int GAP         = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psx_clk = 1'b1;
  logic        att = 1'b1;
  logic        cmd = 1'b1;
  logic        analog_mode = 1'b0;
  logic [15:0] buttons = 16'hFFFF;
  logic [31:0] sticks = 32'h0;
  logic        data, ack, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int         exp_ack_q[$];
  bit         mon_en = 1'b0;
  int         cyc = 0;

  psx_controller_emu #(
    .SYNC_STAGES(SYNC_STAGES), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH),
    .DIGITAL_ID(8'h41), .ANALOG_ID(8'h73)
  ) dut (
    .clk(clk), .rst(rst), .psx_clk(psx_clk), .att(att), .cmd(cmd),
    .buttons(buttons), .sticks(sticks), .analog_mode(analog_mode),
    .data(data), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: all pins are sampled on the falling clk edge, away from DUT updates.
  int         nbits = 0, ack_cnt = 0, ack_w = 0, rise_cyc = 0;
  logic [7:0] shreg = 8'h0;
  logic       pclk_prev = 1'b1, att_prev = 1'b1, ack_prev = 1'b1;
  bit         in_pulse = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (psx_clk && !pclk_prev && !att) begin
        rise_cyc = cyc;
        shreg    = {data, shreg[7:1]};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL reply_byte: got %0h expected none", shreg);
          end else begin
            check("reply_byte", 32'(shreg), 32'(exp_q.pop_front()));
          end
        end
      end
      if (att && !att_prev) begin
        nbits = 0;
        if (exp_ack_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ack_count: got %0d expected none", ack_cnt);
        end else begin
          check("ack_count", 32'(ack_cnt), 32'(exp_ack_q.pop_front()));
        end
        ack_cnt = 0;
      end
      if (ack_prev && !ack) begin
        ack_cnt++;
        check("ack_delay", 32'(cyc - rise_cyc), 32'(SYNC_STAGES + 1 + ACK_DELAY));
        ack_w    = 1;
        in_pulse = 1'b1;
      end else if (!ack) begin
        ack_w++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (!rst) check("ack_width", 32'(ack_w), 32'(ACK_WIDTH));
      end
    end
    pclk_prev = psx_clk;
    att_prev  = att;
    ack_prev  = ack;
  end

  // Reference model: reply slots by byte number, then abort rules on the host bytes.
  task automatic expect_poll(input logic am, input logic [15:0] b, input logic [31:0] s,
                             input logic [7:0] c0, input logic [7:0] c1, input int nh,
                             output int acks, output logic alive);
    logic [7:0] rep[9];
    int n;
    rep = '{8'hFF, am ? 8'h73 : 8'h41, 8'h5A, b[7:0], b[15:8],
            s[7:0], s[15:8], s[23:16], s[31:24]};
    n     = am ? 9 : 5;
    acks  = 0;
    alive = 1'b1;
    for (int i = 0; i < nh; i++) begin
      exp_q.push_back(alive ? rep[i] : 8'hFF);
      if (alive) begin
        if ((i == 0 && c0 != 8'h01) || (i == 1 && c1 != 8'h42) || i == n - 1) alive = 1'b0;
        else acks++;
      end
    end
  endtask

  task automatic host_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      psx_clk = 1'b0; cmd = v[k]; wait_clk(HALF);
      psx_clk = 1'b1;             wait_clk(HALF);
    end
  endtask

  task automatic poll(input logic am, input logic [15:0] b, input logic [31:0] s,
                      input logic [7:0] c0, input logic [7:0] c1, input int nh,
                      input int abort_bits, input int chg_byte, input logic [15:0] chg_val);
    int   acks;
    logic alive;
    logic [7:0] v;
    analog_mode = am; buttons = b; sticks = s;
    expect_poll(am, b, s, c0, c1, nh, acks, alive);
    exp_ack_q.push_back(acks);
    att = 1'b0;
    wait_clk(8);
    analog_mode = ~am;
    sticks      = $urandom;
    for (int i = 0; i < nh; i++) begin
      if (i == chg_byte) buttons = chg_val;
      v = (i == 0) ? c0 : (i == 1) ? c1 : 8'($urandom);
      host_byte(v);
      wait_clk(GAP);
    end
    if (abort_bits > 0) begin
      for (int k = 0; k < abort_bits; k++) begin
        psx_clk = 1'b0; cmd = 1'b0; wait_clk(HALF);
        psx_clk = 1'b1;             wait_clk(HALF);
      end
    end else begin
      check("busy_end", 32'(busy), 32'(alive));
    end
    att = 1'b1;
    if (abort_bits > 0) begin
      wait_clk(SYNC_STAGES + 1);
      check("abort_data", 32'(data), 32'd1);
      check("abort_ack", 32'(ack), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_state", 32'(dut.state_q == ST_IDLE), 32'd1);
    end
    wait_clk(8);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic am;
    logic [7:0] c0, c1;
    int waited;

    wait_clk(3);
    check("reset_data", 32'(data), 32'd1);
    check("reset_ack", 32'(ack), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clk(4);
    mon_en = 1'b1;

    poll(1'b0, 16'hFDFE, 32'h0, 8'h01, 8'h42, 5, 0, -1, 16'h0);
    poll(1'b1, 16'h1234, 32'h80807F10, 8'h01, 8'h42, 9, 0, -1, 16'h0);
    poll(1'b0, 16'($urandom), $urandom, 8'h81, 8'h42, 3, 0, -1, 16'h0);
    poll(1'b0, 16'hBEEF, $urandom, 8'h01, 8'h42, 5, 0, -1, 16'h0);
    poll(1'b1, 16'($urandom), $urandom, 8'h01, 8'h42, 3, 4, -1, 16'h0);
    poll(1'b0, 16'hFFFF, $urandom, 8'h01, 8'h42, 5, 0, 2, 16'hFFFE);
    poll(1'b1, 16'hFFFF, 32'h0, 8'h01, 8'h43, 4, 0, -1, 16'h0);

    // Reset while ack is held low after byte 0.
    exp_q.push_back(8'hFF);
    exp_ack_q.push_back(1);
    analog_mode = 1'b0;
    att = 1'b0;
    wait_clk(8);
    host_byte(8'h01);
    waited = 0;
    while (ack !== 1'b0 && waited < 40) begin
      wait_clk(1);
      waited++;
    end
    check("ack_low_seen", 32'(ack), 32'd0);
    rst = 1'b1;
    wait_clk(1);
    check("rst_ack", 32'(ack), 32'd1);
    check("rst_data", 32'(data), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    att = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    poll(1'b0, 16'h5AA5, 32'h0, 8'h01, 8'h42, 5, 0, -1, 16'h0);

    for (int t = 0; t < 6; t++) begin
      am = 1'($urandom);
      c0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
      c1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h42;
      poll(am, 16'($urandom), $urandom, c0, c1, am ? 9 : 5, 0, -1, 16'h0);
    end

    wait_clk(10);
    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("acks_left", 32'(exp_ack_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
